// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: block geometry, initial hash values, padder FSM
// encoding and the final-word padding helper.
package sha1_pkg;

    localparam int unsigned BlockWidth = 512;
    localparam int unsigned WordSize   = 32;
    localparam int unsigned LenWidth   = 64;
    localparam int unsigned NumWords   = BlockWidth / WordSize;

    localparam logic [31:0] H0 = 32'h67452301;
    localparam logic [31:0] H1 = 32'hEFCDAB89;
    localparam logic [31:0] H2 = 32'h98BADCFE;
    localparam logic [31:0] H3 = 32'h10325476;
    localparam logic [31:0] H4 = 32'hC3D2E1F0;

    typedef enum logic [1:0] {
        StFill  = 2'd0,
        StEmit  = 2'd1,
        StExtra = 2'd2
    } sha1_pad_fsm_e;

    function automatic logic [2:0] sha1_clamp_bytes(input logic [2:0] nbytes);
        return (nbytes > 3'd4) ? 3'd4 : nbytes;
    endfunction

    // Keep the first nbytes bytes, put 0x80 right after them, zero the rest.
    // With nbytes=4 the word is returned unchanged.
    function automatic logic [31:0] sha1_pad_word(input logic [31:0] data,
                                                  input logic [2:0]  nbytes);
        logic [2:0]  n;
        logic [31:0] res;
        n   = sha1_clamp_bytes(nbytes);
        res = data;
        for (int i = 0; i < 4; i++) begin
            if (i == int'(n)) begin
                res[31-8*i -: 8] = 8'h80;
            end else if (i > int'(n)) begin
                res[31-8*i -: 8] = 8'h00;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs 32-bit message words into 512-bit blocks and
// appends the 0x80 marker, zero fill and 64-bit big-endian bit length.
module sha1_padder #(
    parameter int unsigned BlockWidth = 512,
    parameter int unsigned WordWidth  = 32,
    parameter int unsigned LenWidth   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [WordWidth-1:0]  msg_data_i,
    input  logic                  msg_valid_i,
    input  logic                  msg_last_i,
    input  logic [2:0]            msg_bytes_i,
    output logic                  msg_ready_o,
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_valid_o,
    output logic                  block_last_o,
    input  logic                  block_ready_i
);
    import sha1_pkg::*;

    sha1_pad_fsm_e r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [LenWidth-1:0] r_len, w_len_nxt;
    // Word n of the block lives in element 15-n so word 0 lands in the top bits.
    logic [NumWords-1:0][WordWidth-1:0] r_buf, w_buf_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_last, w_last_nxt;
    logic          r_extra, w_extra_nxt;
    logic          r_pad80, w_pad80_nxt;

    logic [2:0]          w_bytes;
    logic [LenWidth-1:0] w_len_add;
    logic [LenWidth-1:0] w_len_word;
    logic [3:0]          w_widx;
    logic                w_fits;

    assign w_bytes    = sha1_clamp_bytes(msg_bytes_i);
    assign w_len_add  = r_len + LenWidth'({w_bytes, 3'b000});
    assign w_len_word = r_len + LenWidth'(WordWidth);
    assign w_widx     = 4'd15 - r_cnt;
    // Length fits in this block when the 0x80 byte lands at position 55 or below.
    assign w_fits     = (r_cnt < 4'd13) || ((r_cnt == 4'd13) && (w_bytes != 3'd4));

    assign msg_ready_o   = (r_state == StFill) && !clear_i;
    assign block_o       = r_buf;
    assign block_valid_o = r_valid;
    assign block_last_o  = r_last;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_buf_nxt   = r_buf;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_extra_nxt = r_extra;
        w_pad80_nxt = r_pad80;

        if (clear_i) begin
            w_state_nxt = StFill;
            w_cnt_nxt   = '0;
            w_len_nxt   = '0;
            w_buf_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_extra_nxt = 1'b0;
            w_pad80_nxt = 1'b0;
        end else begin
            case (r_state)
                StFill: begin
                    if (msg_valid_i) begin
                        if (!msg_last_i) begin
                            w_buf_nxt[w_widx] = msg_data_i;
                            w_len_nxt         = w_len_word;
                            w_cnt_nxt         = r_cnt + 4'd1;
                            if (r_cnt == 4'd15) begin
                                w_valid_nxt = 1'b1;
                                w_last_nxt  = 1'b0;
                                w_state_nxt = StEmit;
                            end
                        end else begin
                            w_len_nxt = w_len_add;
                            for (int e = 0; e < 16; e++) begin
                                if (4'(e) < w_widx) begin
                                    w_buf_nxt[e] = '0;
                                end
                            end
                            w_buf_nxt[w_widx] = sha1_pad_word(msg_data_i, w_bytes);
                            if ((r_cnt == 4'd15) && (w_bytes == 3'd4)) begin
                                w_extra_nxt = 1'b1;
                                w_pad80_nxt = 1'b1;
                                w_last_nxt  = 1'b0;
                            end else begin
                                if (w_bytes == 3'd4) begin
                                    w_buf_nxt[w_widx - 4'd1] = 32'h8000_0000;
                                end
                                if (w_fits) begin
                                    w_buf_nxt[1] = w_len_add[63:32];
                                    w_buf_nxt[0] = w_len_add[31:0];
                                    w_last_nxt   = 1'b1;
                                end else begin
                                    w_extra_nxt = 1'b1;
                                    w_last_nxt  = 1'b0;
                                end
                            end
                            w_valid_nxt = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = StEmit;
                        end
                    end
                end
                StEmit: begin
                    if (block_ready_i) begin
                        w_valid_nxt = 1'b0;
                        if (r_extra) begin
                            w_state_nxt = StExtra;
                        end else begin
                            if (r_last) begin
                                w_len_nxt = '0;
                                w_cnt_nxt = '0;
                                w_buf_nxt = '0;
                            end
                            w_last_nxt  = 1'b0;
                            w_state_nxt = StFill;
                        end
                    end
                end
                StExtra: begin
                    w_buf_nxt     = '0;
                    w_buf_nxt[15] = r_pad80 ? 32'h8000_0000 : 32'h0;
                    w_buf_nxt[1]  = r_len[63:32];
                    w_buf_nxt[0]  = r_len[31:0];
                    w_extra_nxt   = 1'b0;
                    w_pad80_nxt   = 1'b0;
                    w_valid_nxt   = 1'b1;
                    w_last_nxt    = 1'b1;
                    w_state_nxt   = StEmit;
                end
                default: w_state_nxt = StFill;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StFill;
            r_cnt   <= '0;
            r_len   <= '0;
            r_buf   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_extra <= 1'b0;
            r_pad80 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_buf   <= w_buf_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_extra <= w_extra_nxt;
            r_pad80 <= w_pad80_nxt;
        end
    end

endmodule

// File: tb/tb_sha1_padder.sv
// Directed bench for sha1_padder: padding layouts, multi-block messages,
// backpressure, clear and asynchronous reset.
module tb_sha1_padder;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clear_i;
    logic [31:0]  msg_data_i;
    logic         msg_valid_i;
    logic         msg_last_i;
    logic [2:0]   msg_bytes_i;
    logic         msg_ready_o;
    logic [511:0] block_o;
    logic         block_valid_o;
    logic         block_last_o;
    logic         block_ready_i;

    int n_cmp = 0;
    int n_err = 0;
    logic [511:0] exp_blk;
    logic [511:0] abc_blk;

    sha1_padder dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .msg_data_i    (msg_data_i),
        .msg_valid_i   (msg_valid_i),
        .msg_last_i    (msg_last_i),
        .msg_bytes_i   (msg_bytes_i),
        .msg_ready_o   (msg_ready_o),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_last_o  (block_last_o),
        .block_ready_i (block_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        exp_blk[511-32*idx -: 32] = val;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [2:0] b);
        @(negedge clk_i);
        msg_data_i  = d;
        msg_last_i  = l;
        msg_bytes_i = b;
        msg_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
    endtask

    task automatic wait_block(input string tag);
        int k;
        k = 0;
        @(negedge clk_i);
        while (!block_valid_o && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        chk(tag, 512'(block_valid_o), 512'(1'b1));
    endtask

    task automatic take();
        block_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        block_ready_i = 1'b0;
    endtask

    task automatic expect_block(input string tag, input logic last);
        wait_block({tag, "_valid"});
        chk({tag, "_data"}, block_o, exp_blk);
        chk({tag, "_last"}, 512'(block_last_o), 512'(last));
        take();
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; msg_data_i = '0; msg_valid_i = 1'b0;
        msg_last_i = 1'b0; msg_bytes_i = '0; block_ready_i = 1'b0;

        abc_blk = '0;
        abc_blk[511:480] = 32'h6162_6380;
        abc_blk[31:0]    = 32'h0000_0018;

        repeat (2) @(negedge clk_i);
        chk("rst_block", block_o, 512'h0);
        chk("rst_valid", 512'(block_valid_o), 512'h0);
        chk("rst_last", 512'(block_last_o), 512'h0);
        chk("rst_ready", 512'(msg_ready_o), 512'h1);
        rst_ni = 1'b1;

        // "abc"
        send(32'h6162_6300, 1'b1, 3'd3);
        exp_blk = abc_blk;
        expect_block("abc", 1'b1);
        @(negedge clk_i);
        chk("abc_drop", 512'(block_valid_o), 512'h0);
        chk("abc_ready", 512'(msg_ready_o), 512'h1);

        // Empty message
        send(32'hDEAD_BEEF, 1'b1, 3'd0);
        exp_blk = '0;
        set_word(0, 32'h8000_0000);
        expect_block("empty", 1'b1);

        // msg_bytes_i=7 is clamped to 4: "abcd"
        send(32'h6162_6364, 1'b1, 3'd7);
        exp_blk = '0;
        set_word(0, 32'h6162_6364);
        set_word(1, 32'h8000_0000);
        set_word(15, 32'h0000_0020);
        expect_block("clamp", 1'b1);

        // 56 bytes: length spills into a second block
        for (int i = 0; i < 14; i++) send(32'hA000_0000 + 32'(i), (i == 13), 3'd4);
        exp_blk = '0;
        for (int i = 0; i < 14; i++) set_word(i, 32'hA000_0000 + 32'(i));
        set_word(14, 32'h8000_0000);
        expect_block("b56_1", 1'b0);
        exp_blk = '0;
        set_word(15, 32'h0000_01C0);
        expect_block("b56_2", 1'b1);

        // 64 bytes: data block unchanged, 0x80 in the extra block
        for (int i = 0; i < 16; i++) send(32'hB000_0000 + 32'(i), (i == 15), 3'd4);
        exp_blk = '0;
        for (int i = 0; i < 16; i++) set_word(i, 32'hB000_0000 + 32'(i));
        expect_block("b64_1", 1'b0);
        exp_blk = '0;
        set_word(0, 32'h8000_0000);
        set_word(15, 32'h0000_0200);
        expect_block("b64_2", 1'b1);

        // 65 bytes: full non-last block, then a 1-byte tail
        for (int i = 0; i < 16; i++) send(32'hC000_0000 + 32'(i), 1'b0, 3'd0);
        exp_blk = '0;
        for (int i = 0; i < 16; i++) set_word(i, 32'hC000_0000 + 32'(i));
        expect_block("b65_1", 1'b0);
        send(32'h7788_99AA, 1'b1, 3'd1);
        exp_blk = '0;
        set_word(0, 32'h7780_0000);
        set_word(15, 32'h0000_0208);
        expect_block("b65_2", 1'b1);

        // Backpressure for 10 cycles
        send(32'h6162_6300, 1'b1, 3'd3);
        wait_block("bp_valid");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_data%0d", i), block_o, abc_blk);
            chk($sformatf("bp_last%0d", i), 512'(block_last_o), 512'h1);
            chk($sformatf("bp_ready%0d", i), 512'(msg_ready_o), 512'h0);
            @(negedge clk_i);
        end
        chk("bp_still_valid", 512'(block_valid_o), 512'h1);
        take();
        @(negedge clk_i);
        chk("bp_after_valid", 512'(block_valid_o), 512'h0);
        chk("bp_after_ready", 512'(msg_ready_o), 512'h1);

        // clear after 5 words, then "abc"
        for (int i = 0; i < 5; i++) send(32'hFFFF_FFF0 + 32'(i), 1'b0, 3'd0);
        @(negedge clk_i);
        clear_i = 1'b1;
        msg_valid_i = 1'b1;
        msg_data_i = 32'h1234_5678;
        #1;
        chk("clr_ready", 512'(msg_ready_o), 512'h0);
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        msg_valid_i = 1'b0;
        send(32'h6162_6300, 1'b1, 3'd3);
        exp_blk = abc_blk;
        expect_block("clr_abc", 1'b1);

        // Async reset during EMIT
        send(32'h6162_6300, 1'b1, 3'd3);
        wait_block("rst_emit_valid");
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_emit_drop", 512'(block_valid_o), 512'h0);
        chk("rst_emit_block", block_o, 512'h0);
        chk("rst_emit_last", 512'(block_last_o), 512'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        send(32'h6162_6300, 1'b1, 3'd3);
        exp_blk = abc_blk;
        expect_block("post_rst_abc", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha1_padder.md
Name: sha1_padder

Overview:
- Message-side front end for sha1_core. Accepts a byte-oriented message as a stream of 32-bit words with valid/ready.
- Applies FIPS 180-4 padding: appends 0x80, zero fill, then the 64-bit big-endian bit length.
- Emits complete 512-bit blocks over a valid/ready handshake, with a last-block flag.
- The system controller forwards each emitted block to the core's block_i and drives enable_hash_i accordingly.

Parameters:
- BlockWidth, 512, block width in bits. Only the default is supported.
- WordWidth, 32, input word width in bits. Only the default is supported.
- LenWidth, 64, message-length field width in bits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous abort: drop the partial block and zero the length
- msg_data_i  in  32  message word; first byte in [31:24]
- msg_valid_i  in  1  msg_data_i valid
- msg_last_i  in  1  final word of the message
- msg_bytes_i  in  3  valid bytes in the final word, 0..4; ignored unless msg_last_i=1
- msg_ready_o  out  1  padder accepts a word this cycle
- block_o  out  512  padded block; word 0 in [511:480]
- block_valid_o  out  1  block_o valid
- block_last_o  out  1  block_o is the final block of the message
- block_ready_i  in  1  consumer accepts block_o

Behaviour:
- Reset values:
  - block_o=0, block_valid_o=0, block_last_o=0.
  - Word counter=0, bit-length counter=0, state=FILL.
  - msg_ready_o=1 once out of reset.
- FSM states: FILL, EMIT, EXTRA.
- FILL:
  - msg_ready_o=1.
  - On msg_valid_i&msg_ready_o, write the word at index cnt (0..15) into the buffer.
  - Non-last word: length += 32, then cnt++.
    - If cnt was 15: block_valid_o=1 and block_last_o=0 on the next cycle; go to EMIT, cnt=0.
  - Last word: length += 8*msg_bytes_i. Byte position p = 4*cnt + msg_bytes_i. Bytes after p in that word are zeroed.
    - p<=55: 0x80 goes at byte p, bytes p+1..55 are zero, bytes 56..63 hold the updated length. block_last_o=1. Go to EMIT.
    - 56<=p<=63: 0x80 goes at byte p, the rest of the block is zero. block_last_o=0. Set extra_pending; go to EMIT.
    - p=64 (cnt=15, msg_bytes_i=4): the data block is emitted unchanged. block_last_o=0. Set extra_pending and pad80_pending; go to EMIT.
  - Latency: the block is valid on the cycle after the accepting edge.
- EMIT:
  - msg_ready_o=0.
  - block_o, block_valid_o and block_last_o stay stable while block_ready_i=0.
  - On block_valid_o&block_ready_i:
    - block_valid_o drops next cycle.
    - If extra_pending: go to EXTRA.
    - Else if block_last_o: clear length, cnt and buffer; go to FILL.
    - Else: go to FILL.
- EXTRA (one cycle):
  - Builds a block of zeros with the length in bytes 56..63; byte 0 = 0x80 if pad80_pending.
  - Clears both pending flags; sets block_valid_o=1 and block_last_o=1; go to EMIT.
- Arithmetic and layout:
  - Length counter is LenWidth bits and wraps modulo 2^64.
  - Length is placed big-endian: word 14 = high 32 bits, word 15 = low 32 bits.
- Boundary rules:
  - msg_bytes_i>4 on a last word is treated as 4.
  - msg_last_i with msg_bytes_i=0 at cnt=0 and length 0 yields the empty-message block.
- clear_i:
  - Takes precedence over everything in any state.
  - Next cycle: state=FILL, cnt=0, length=0, flags=0, block_valid_o=0, block_last_o=0, buffer zeroed.
  - The input word presented in the same cycle is not accepted: msg_ready_o=0 while clear_i=1.
- Reset mid-operation: asynchronous return to the reset values; any in-flight block is lost.

Decomposition:
- Shared package sha1_pkg holds:
  - BlockWidth, WordSize, LenWidth and NumWords constants.
  - The H0–H4 initial-value constants, shared with sha1_core.
  - The padder state enum sha1_pad_fsm_e.
- Byte-insertion helper: function in the package, mask and insert 0x80 into a word given a byte count.
- No sub-module. Buffer, counters and FSM are a single module.

Test Plan:
- "abc" as one last word 0x61626300, bytes=3:
  - One block: word0=0x61626380, words1–14=0, word15=0x00000018, last=1.
  - Feeding it to sha1_core gives digest a9993e36...9cd0d89d.
- Empty message (last, bytes=0, cnt=0): word0=0x80000000, words1–15=0, last=1.
- 56-byte message (14 full words, last bytes=4): two blocks.
  - Block 1: data in words 0–13, word14=0x80000000, word15=0, last=0.
  - Block 2: zeros, word15=0x000001C0, last=1.
- 64-byte message (16 full words, last at cnt=15): two blocks.
  - Block 1: raw data, last=0.
  - Block 2: word0=0x80000000, word15=0x00000200, last=1.
- Backpressure: hold block_ready_i=0 for 10 cycles after block_valid_o rises.
  - block_o and block_last_o remain constant, msg_ready_o=0.
  - Accepted on the 11th cycle; msg_ready_o=1 next cycle.
- clear_i asserted after 5 accepted words, then "abc":
  - Output identical to scenario 1 (length 0x18, no stale data).
  - Separately, asserting rst_ni low during EMIT forces block_valid_o=0 immediately.
